// File: rtl/rom_fetch_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rom_fetch_arbiter_pkg
// Shared definitions for the ROM fetch arbiter: FSM state encoding, grant
// identifiers, default SDRAM base offsets and cache tag widths.
// ----------------------------------------------------------------------------
package rom_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL
    } state_t;

    // Grant identifiers; also the encoding of the last_grant register.
    localparam logic GRANT_M68K = 1'b0;
    localparam logic GRANT_Z80  = 1'b1;

    // Default SDRAM byte offsets of the two ROM regions.
    localparam logic [23:0] DEF_M68K_BASE = 24'h000000;
    localparam logic [23:0] DEF_Z80_BASE  = 24'h040000;

    // Cache tags are word addresses.
    localparam int M68K_TAG_W = 17;
    localparam int Z80_TAG_W  = 15;

endpackage

// File: rtl/rom_fetch_arbiter_cache_line.sv
// ----------------------------------------------------------------------------
// rom_cache_line
// One-entry read cache: a word-address tag, a 16-bit data word and a valid
// bit, plus the hit compare against the current lookup address.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   i_wr            write strobe (fill from SDRAM)
//   i_wr_tag        tag stored on fill
//   i_wr_data       data word stored on fill
//   i_lookup_tag    word address currently presented by the CPU
//   o_hit           valid and tag matches the lookup address
//   o_data          cached data word
// ----------------------------------------------------------------------------
module rom_cache_line #(
    parameter int TAG_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [15:0]      i_wr_data,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_hit,
    output logic [15:0]      o_data
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_data;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
        end
    end

    // NOTE: tag and data are storage, not control; only the valid bit needs a
    // reset because nothing reads them while valid is clear.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_tag  <= i_wr_tag;
            r_data <= i_wr_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// rom_fetch_arbiter
// Shares the single SDRAM ROM read port between the M68K program ROM and the
// Z80 sound ROM. Each side has a one-word cache; misses are queued as pending
// flags and served round-robin. Produces the M68K data-ready (DTACK source)
// and the Z80 WAIT_n.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   m68k_rom_cs     decoded M68K ROM select (qualified by AS)
//   m68k_a          M68K word address [17:1]
//   m68k_rom_dout   registered read data to the M68K
//   m68k_rom_ok     registered data valid (DTACK source)
//   z80_rom_cs      decoded Z80 ROM select (qualified by MREQ)
//   z80_addr        Z80 byte address
//   z80_rom_dout    read byte to the Z80 (combinational from the cache)
//   z80_wait_n      low while a Z80 miss is outstanding (combinational)
//   rom_req         SDRAM read request, level, held until rom_ack
//   rom_addr        SDRAM byte address, always even
//   rom_ack         one-cycle acknowledge, rom_data valid with it
//   rom_data        SDRAM read word
// ----------------------------------------------------------------------------
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter logic [23:0] M68K_BASE = DEF_M68K_BASE,
    parameter logic [23:0] Z80_BASE  = DEF_Z80_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m68k_rom_cs,
    input  logic [16:0] m68k_a,
    output logic [15:0] m68k_rom_dout,
    output logic        m68k_rom_ok,
    input  logic        z80_rom_cs,
    input  logic [15:0] z80_addr,
    output logic [7:0]  z80_rom_dout,
    output logic        z80_wait_n,
    output logic        rom_req,
    output logic [23:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data
);

    state_t                  r_state;
    logic                    r_last_grant;
    logic                    r_rom_req;
    logic [23:0]             r_rom_addr;
    logic                    r_m68k_ok;
    logic [15:0]             r_m68k_dout;
    logic                    r_m68k_pend;
    logic                    r_z80_pend;
    logic [M68K_TAG_W-1:0]   r_m68k_tag;
    logic [Z80_TAG_W-1:0]    r_z80_tag;

    logic                    w_m68k_line_hit;
    logic                    w_z80_line_hit;
    logic [15:0]             w_m68k_line_data;
    logic [15:0]             w_z80_line_data;
    logic [Z80_TAG_W-1:0]    w_z80_word;
    logic                    w_m68k_hit;
    logic                    w_m68k_miss;
    logic                    w_z80_hit;
    logic                    w_z80_miss;
    logic                    w_m68k_want;
    logic                    w_z80_want;
    logic [M68K_TAG_W-1:0]   w_m68k_tag_eff;
    logic [Z80_TAG_W-1:0]    w_z80_tag_eff;
    logic                    w_grant;
    logic                    w_fill;
    logic                    w_m68k_wr;
    logic                    w_z80_wr;

    assign w_z80_word  = z80_addr[15:1];

    assign w_m68k_hit  = m68k_rom_cs && w_m68k_line_hit;
    assign w_m68k_miss = m68k_rom_cs && !w_m68k_line_hit;
    assign w_z80_hit   = z80_rom_cs && w_z80_line_hit;
    assign w_z80_miss  = z80_rom_cs && !w_z80_line_hit;

    // A fresh miss competes in the same cycle it appears; an already pending
    // side competes with its latched address.
    assign w_m68k_want    = r_m68k_pend || w_m68k_miss;
    assign w_z80_want     = r_z80_pend || w_z80_miss;
    assign w_m68k_tag_eff = r_m68k_pend ? r_m68k_tag : m68k_a;
    assign w_z80_tag_eff  = r_z80_pend ? r_z80_tag : w_z80_word;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant = GRANT_Z80;
        if (w_m68k_want && w_z80_want) begin
            w_grant = (r_last_grant == GRANT_Z80) ? GRANT_M68K : GRANT_Z80;
        end else if (w_m68k_want) begin
            w_grant = GRANT_M68K;
        end
    end

    // r_last_grant doubles as the owner of the request in flight.
    assign w_fill    = (r_state == ST_REQ) && rom_ack;
    assign w_m68k_wr = w_fill && (r_last_grant == GRANT_M68K);
    assign w_z80_wr  = w_fill && (r_last_grant == GRANT_Z80);

    rom_cache_line #(.TAG_W(M68K_TAG_W)) u_m68k_line (
        .clk          (clk),
        .reset        (reset),
        .i_wr         (w_m68k_wr),
        .i_wr_tag     (r_m68k_tag),
        .i_wr_data    (rom_data),
        .i_lookup_tag (m68k_a),
        .o_hit        (w_m68k_line_hit),
        .o_data       (w_m68k_line_data)
    );

    rom_cache_line #(.TAG_W(Z80_TAG_W)) u_z80_line (
        .clk          (clk),
        .reset        (reset),
        .i_wr         (w_z80_wr),
        .i_wr_tag     (r_z80_tag),
        .i_wr_data    (rom_data),
        .i_lookup_tag (w_z80_word),
        .o_hit        (w_z80_line_hit),
        .o_data       (w_z80_line_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_Z80;
            r_rom_req    <= 1'b0;
            r_rom_addr   <= 24'h000000;
            r_m68k_ok    <= 1'b0;
            r_m68k_dout  <= 16'h0000;
            r_m68k_pend  <= 1'b0;
            r_z80_pend   <= 1'b0;
            r_m68k_tag   <= '0;
            r_z80_tag    <= '0;
        end else begin
            r_m68k_ok <= w_m68k_hit;
            if (w_m68k_hit) begin
                r_m68k_dout <= w_m68k_line_data;
            end

            // Latch a miss only once; an address change while pending is
            // picked up as a new miss after the current fill completes.
            if (w_m68k_miss && !r_m68k_pend) begin
                r_m68k_pend <= 1'b1;
                r_m68k_tag  <= m68k_a;
            end
            if (w_z80_miss && !r_z80_pend) begin
                r_z80_pend <= 1'b1;
                r_z80_tag  <= w_z80_word;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_m68k_want || w_z80_want) begin
                        r_last_grant <= w_grant;
                        r_rom_req    <= 1'b1;
                        r_rom_addr   <= (w_grant == GRANT_M68K)
                                      ? M68K_BASE + {6'b0, w_m68k_tag_eff, 1'b0}
                                      : Z80_BASE  + {8'b0, w_z80_tag_eff, 1'b0};
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rom_ack) begin
                        r_rom_req <= 1'b0;
                        if (r_last_grant == GRANT_M68K) begin
                            r_m68k_pend <= 1'b0;
                        end else begin
                            r_z80_pend <= 1'b0;
                        end
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m68k_rom_ok   = r_m68k_ok;
    assign m68k_rom_dout = r_m68k_dout;
    assign rom_req       = r_rom_req;
    assign rom_addr      = r_rom_addr;

    // WAIT must be valid in the same T-state the Z80 samples it.
    assign z80_wait_n   = !(z80_rom_cs && !w_z80_line_hit);
    assign z80_rom_dout = w_z80_hit ? (z80_addr[0] ? w_z80_line_data[15:8]
                                                   : w_z80_line_data[7:0])
                                    : 8'h00;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_fetch_arbiter
// Directed bench for rom_fetch_arbiter. Stimulus pushes expected SDRAM
// request addresses, M68K data words and Z80 bytes into queues; a monitor
// pops and compares on each new rom_req, each rising m68k_rom_ok and each
// rising z80_wait_n while the Z80 is selected.
// ----------------------------------------------------------------------------
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m68k_rom_cs;
    logic [16:0] m68k_a;
    logic [15:0] m68k_rom_dout;
    logic        m68k_rom_ok;
    logic        z80_rom_cs;
    logic [15:0] z80_addr;
    logic [7:0]  z80_rom_dout;
    logic        z80_wait_n;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_req[$];
    logic [15:0] exp_m68k[$];
    logic [7:0]  exp_z80[$];

    logic p_req;
    logic p_ok;
    logic p_wait;

    rom_fetch_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .m68k_rom_cs   (m68k_rom_cs),
        .m68k_a        (m68k_a),
        .m68k_rom_dout (m68k_rom_dout),
        .m68k_rom_ok   (m68k_rom_ok),
        .z80_rom_cs    (z80_rom_cs),
        .z80_addr      (z80_addr),
        .z80_rom_dout  (z80_rom_dout),
        .z80_wait_n    (z80_wait_n),
        .rom_req       (rom_req),
        .rom_addr      (rom_addr),
        .rom_ack       (rom_ack),
        .rom_data      (rom_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            p_req  = 1'b0;
            p_ok   = 1'b0;
            p_wait = 1'b1;
        end else begin
            if (rom_req && !p_req) begin
                if (exp_req.size() == 0) check("unexpected_req", 32'(rom_addr), 32'hFFFFFFFF);
                else check("req_addr", 32'(rom_addr), 32'(exp_req.pop_front()));
            end
            if (m68k_rom_ok && !p_ok) begin
                if (exp_m68k.size() == 0) check("unexpected_m68k_ok", 32'(m68k_rom_dout), 32'hFFFFFFFF);
                else check("m68k_dout", 32'(m68k_rom_dout), 32'(exp_m68k.pop_front()));
            end
            if (z80_rom_cs && z80_wait_n && !p_wait) begin
                if (exp_z80.size() == 0) check("unexpected_z80_ready", 32'(z80_rom_dout), 32'hFFFFFFFF);
                else check("z80_dout", 32'(z80_rom_dout), 32'(exp_z80.pop_front()));
            end
            p_req  = rom_req;
            p_ok   = m68k_rom_ok;
            p_wait = z80_wait_n;
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!rom_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(rom_req), 32'd1);
    endtask

    task automatic do_ack(input logic [15:0] d);
        @(negedge clk);
        wait_req();
        rom_ack  = 1'b1;
        rom_data = d;
        @(negedge clk);
        rom_ack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        m68k_rom_cs = 1'b0;
        m68k_a      = '0;
        z80_rom_cs  = 1'b0;
        z80_addr    = '0;
        rom_ack     = 1'b0;
        rom_data    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_m68k_ok", 32'(m68k_rom_ok), 32'd0);
        check("rst_m68k_dout", 32'(m68k_rom_dout), 32'd0);
        check("rst_z80_dout", 32'(z80_rom_dout), 32'd0);
        check("rst_z80_wait_n", 32'(z80_wait_n), 32'd1);
        reset = 1'b0;

        // M68K miss, fill, then hit on re-select
        exp_req.push_back(24'h000004);
        exp_m68k.push_back(16'h4E71);
        m68k_rom_cs = 1'b1;
        m68k_a      = 17'h00002;
        do_ack(16'h4E71);
        @(negedge clk);
        check("m68k_ok_after_fill", 32'(m68k_rom_ok), 32'd1);
        m68k_rom_cs = 1'b0;
        @(negedge clk);
        check("m68k_ok_drop", 32'(m68k_rom_ok), 32'd0);
        exp_m68k.push_back(16'h4E71);
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        check("m68k_hit_ok", 32'(m68k_rom_ok), 32'd1);
        check("m68k_hit_no_req", 32'(rom_req), 32'd0);
        m68k_rom_cs = 1'b0;

        // Z80 miss: WAIT low same cycle, odd byte returned after fill
        exp_req.push_back(24'h040100);
        exp_z80.push_back(8'hA5);
        z80_rom_cs = 1'b1;
        z80_addr   = 16'h0101;
        #1;
        check("z80_wait_low", 32'(z80_wait_n), 32'd0);
        do_ack(16'hA55A);
        @(negedge clk);
        z80_addr = 16'h0100;
        #1;
        check("z80_even_byte", 32'(z80_rom_dout), 32'h5A);
        check("z80_even_wait_n", 32'(z80_wait_n), 32'd1);
        @(negedge clk);
        z80_rom_cs = 1'b0;

        // Simultaneous misses after reset: M68K, Z80, then M68K, Z80
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_req.push_back(24'h000020);
        exp_req.push_back(24'h040200);
        exp_m68k.push_back(16'h1111);
        exp_z80.push_back(8'h22);
        m68k_rom_cs = 1'b1;
        m68k_a      = 17'h00010;
        z80_rom_cs  = 1'b1;
        z80_addr    = 16'h0200;
        do_ack(16'h1111);
        do_ack(16'h2222);
        @(negedge clk);
        exp_req.push_back(24'h000022);
        exp_req.push_back(24'h040300);
        exp_m68k.push_back(16'h3333);
        exp_z80.push_back(8'h44);
        m68k_a   = 17'h00011;
        z80_addr = 16'h0301;
        do_ack(16'h3333);
        do_ack(16'h4444);
        @(negedge clk);
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        @(negedge clk);

        // Reset during REQ abandons the fetch; late ack is ignored
        exp_req.push_back(24'h000040);
        m68k_rom_cs = 1'b1;
        m68k_a      = 17'h00020;
        wait_req();
        @(negedge clk);
        reset       = 1'b1;
        m68k_rom_cs = 1'b0;
        #1;
        check("rst_mid_req", 32'(rom_req), 32'd0);
        check("rst_mid_addr", 32'(rom_addr), 32'd0);
        check("rst_mid_ok", 32'(m68k_rom_ok), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        rom_ack  = 1'b1;
        rom_data = 16'hDEAD;
        @(negedge clk);
        rom_ack = 1'b0;
        exp_req.push_back(24'h000040);
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        check("refetch_req", 32'(rom_req), 32'd1);
        check("refetch_no_ok", 32'(m68k_rom_ok), 32'd0);
        exp_m68k.push_back(16'hBEEF);
        do_ack(16'hBEEF);
        @(negedge clk);

        // CS dropped mid-fetch: cache still fills, later hit needs no request
        exp_req.push_back(24'h000060);
        m68k_a = 17'h00030;
        wait_req();
        m68k_rom_cs = 1'b0;
        do_ack(16'h7777);
        repeat (3) @(negedge clk);
        check("cs_drop_no_ok", 32'(m68k_rom_ok), 32'd0);
        exp_m68k.push_back(16'h7777);
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        check("cs_drop_hit_ok", 32'(m68k_rom_ok), 32'd1);
        check("cs_drop_hit_no_req", 32'(rom_req), 32'd0);

        // Address change during REQ: fill uses latched address, new one re-pends
        exp_req.push_back(24'h000080);
        exp_req.push_back(24'h000082);
        exp_m68k.push_back(16'h8989);
        m68k_a = 17'h00040;
        wait_req();
        m68k_a = 17'h00041;
        do_ack(16'h8888);
        do_ack(16'h8989);
        repeat (2) @(negedge clk);
        m68k_rom_cs = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_req_drain", 32'(exp_req.size()), 32'd0);
        check("sb_m68k_drain", 32'(exp_m68k.size()), 32'd0);
        check("sb_z80_drain", 32'(exp_z80.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single SDRAM ROM read port between the M68K program ROM (0x000000-0x03ffff) and the Z80 sound ROM (0x0000-0xefff).
- Takes the chip-select outputs and CPU addresses from the address decoder.
- Arbitrates misses round-robin, holds a one-word cache per requester, and generates the M68K data-ready (DTACK source) and the Z80 WAIT_n.
- Sits between the decoder/CPU cores and the SDRAM controller.

Parameters:
- M68K_BASE, 24'h000000, SDRAM byte offset of the M68K ROM region.
- Z80_BASE, 24'h040000, SDRAM byte offset of the Z80 ROM region.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m68k_rom_cs  in  1  decoded M68K ROM select (already qualified by AS)
- m68k_a  in  17  M68K word address bits [17:1]
- m68k_rom_dout  out  16  read data to the M68K
- m68k_rom_ok  out  1  data valid; DTACK logic asserts on this
- z80_rom_cs  in  1  decoded Z80 ROM select (already qualified by MREQ)
- z80_addr  in  16  Z80 byte address
- z80_rom_dout  out  8  read byte to the Z80
- z80_wait_n  out  1  low while a Z80 miss is outstanding
- rom_req  out  1  SDRAM read request, level
- rom_addr  out  24  SDRAM byte address, always even
- rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle
- rom_data  in  16  SDRAM read word

Behaviour:
- Reset (async, active-high) clears:
  - rom_req=0, rom_addr=0, m68k_rom_dout=0, z80_rom_dout=0, m68k_rom_ok=0.
  - Both cache valid bits and both pending flags; FSM goes to IDLE.
  - z80_wait_n goes to 1.
  - Reset asserted mid-fetch abandons the fetch. A late rom_ack after reset is ignored because the FSM is in IDLE.
- Cache, one entry per side: a tag (word address) and a 16-bit data word. Tag widths: M68K 17 bits, Z80 15 bits (z80_addr[15:1]).
- Hit definition: cs high, valid set, and tag equals the current address.
  - M68K hit: m68k_rom_ok=1 and m68k_rom_dout=cache data, registered. Latency is 1 clk after cs/address present.
  - Z80 hit: z80_rom_dout = z80_addr[0] ? data[15:8] : data[7:0].
- z80_wait_n = !(z80_rom_cs && !z80_hit). This output is combinational so WAIT is sampled in the same T-state.
- m68k_rom_ok drops in the cycle after m68k_rom_cs deasserts or the address changes to a miss.
- Miss: cs high and no hit sets that side's pending flag and latches the miss address.
- Address mapping for the SDRAM request:
  - M68K: rom_addr = M68K_BASE + {m68k_a,1'b0}.
  - Z80: rom_addr = Z80_BASE + {z80_addr[15:1],1'b0}.
- FSM states: IDLE, REQ, FILL.
  - IDLE: if any side is pending, pick a winner, drive rom_addr, set rom_req=1, go to REQ.
  - REQ: hold rom_req and rom_addr stable until rom_ack.
  - On ack: write rom_data into the winner's cache, set its valid bit, set its tag to the latched address, clear pending, set rom_req=0, go to FILL.
  - FILL: one cycle, lets the hit path settle, then return to IDLE. No back-to-back requests; minimum 1 idle cycle between requests.
- Arbitration:
  - Round-robin using a last_grant bit.
  - When both sides are pending, the side not granted last wins.
  - A single pending side always wins.
  - Reset value of last_grant is Z80, so M68K wins the first tie.
- Edge cases:
  - CS deasserted during a fetch: the fetch completes and the cache fills; no output is driven.
  - Address changes on the granted side during REQ: the fill uses the latched address. The new address misses and re-pends after FILL.
  - Simultaneous new misses in IDLE: resolved by round-robin in the same cycle.
  - Both sides target the same SDRAM word: no coherence is needed (ROM is read-only).
- Address widths: rom_addr adders are 24-bit; overflow wraps and is not flagged.

Decomposition:
- Shared package holds:
  - The FSM state enum (IDLE/REQ/FILL).
  - The GRANT_M68K/GRANT_Z80 constants.
  - Default base offsets.
- One natural sub-module: rom_cache_line. It is parameterised on tag width and holds tag, data and valid, plus hit compare. It is instantiated twice.

Test Plan:
- Reset, then m68k_rom_cs=1, m68k_a=0x00002 -> rom_req=1 with rom_addr=0x000004. On ack, rom_data=0x4E71 -> m68k_rom_ok=1 and dout=0x4E71 one clk later.
- Repeat the same M68K address after cs toggles -> no rom_req; m68k_rom_ok=1 one clk after cs.
- z80_rom_cs=1, z80_addr=0x0101 -> z80_wait_n=0 the same cycle and rom_addr=0x040100. On ack, rom_data=0xA55A -> z80_wait_n=1 and z80_rom_dout=0xA5.
- Both miss in the same cycle after reset -> M68K is granted first and Z80 second. With both continuously missing afterwards, grants alternate Z80, M68K, ...
- Reset pulsed while in REQ -> rom_req=0 immediately and caches invalid; a later ack pulse causes no cache write.
- M68K cs dropped mid-fetch -> ack still fills the cache; re-asserting the same address hits with no new request.
